alu_ctrl_issue: RTL and testbench
=================================

// Module: alu_ctrl_issue
// PURPOSE
//  Registered, handshaked successor to the combinational ALU control decoder. Decodes ALUOp/Funct3/Funct7
//  into an OP_W-bit ALU operation and adds SLTU plus M-extension ops. Sits between ID and EX.
//  Holds a decoded op until EX accepts it, and stalls ID for the duration of multi-cycle MUL/DIV ops.
// PARAMETERS
//  OP_W     5   operation code width; must be >= 5 (bit 4 = M-ext group)
//  MUL_LAT  3   cycles from accept to out_valid for MUL* ops (>= 2)
//  DIV_LAT  33  cycles from accept to out_valid for DIV*/REM* ops (>= 2)
// PORTS
//  clk          in   1     clock, rising edge
//  reset        in   1     asynchronous, active-high reset
//  in_valid     in   1     ID presents an instruction
//  in_ready     out  1     block accepts the instruction this cycle
//  in_aluop     in   2     00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI
//  in_rtype     in   1     1 = R-type (Funct7 is meaningful), 0 = I-type
//  in_funct3    in   3     instr[14:12]
//  in_funct7    in   7     instr[31:25]
//  in_flush     in   1     pipeline flush (branch mispredict / trap)
//  out_valid    out  1     decoded op is valid
//  out_ready    in   1     EX consumes the op
//  out_op       out  OP_W  operation code (alu_ctrl_pkg::op_e)
//  out_illegal  out  1     undecodable combination; out_op = OP_ILLEGAL
//  out_multi    out  1     op came from the multi-cycle path
//  busy         out  1     multi-cycle countdown in progress
// BEHAVIOUR
//  - Reset: FSM=IDLE, out_valid=0, out_op=OP_ADD, out_illegal=0, out_multi=0, busy=0, counter=0.
//  - Accept = in_valid & in_ready & ~in_flush. in_ready = ~busy & (~out_valid | out_ready).
//  - FSM states:
//    - IDLE: holds no valid output.
//    - WAIT: counting; busy=1, out_valid=0.
//    - VALID: out_valid=1.
//  - Transitions:
//    - single-cycle op accepted at cycle N -> VALID, out_valid=1 at N+1.
//    - multi-cycle op accepted at N -> WAIT, counter=LAT-1; decrements each cycle; at 1 -> VALID.
//      out_valid first high at N+LAT.
//    - VALID & out_ready & no accept -> IDLE. VALID & out_ready & accept -> back-to-back (new op at next cycle).
//  - out_op/out_illegal/out_multi are stable while out_valid & ~out_ready.
//  - in_flush (priority over all): next cycle out_valid=0, busy=0, counter=0, FSM=IDLE; no accept that cycle.
//  - Decode (4-bit base codes zero-extended to OP_W):
//    - AND 0000, OR 0001, LUI 0010, XOR 0011, SLL 0100, SRL 0101, BLT 0110, BGE 0111.
//    - BEQ 1000, BNE 1001, SUB 1010, ADD 1011, SLT 1100, SRA 1101, SLTU 1110.
//    - ALUOp 00 -> ADD; 11 -> LUI.
//    - ALUOp 01: f3 000/001/100/101 -> BEQ/BNE/BLT/BGE; other f3 -> illegal.
//    - ALUOp 10: f3 000 -> SUB only if in_rtype & f7=0100000, else ADD; 001 SLL; 010 SLT; 011 SLTU;
//      100 XOR; 101 f7[5]?SRA:SRL; 110 OR; 111 AND.
//    - R-type with f7 not in {0000000,0100000,0000001} -> illegal; illegal ops are single-cycle.
//  - OP_ILLEGAL = all ones (OP_W bits).
// CONFIGURATION
//  - ALU_CTRL_MEXT_EN defined:
//    - R-type f7=0000001 decodes to M group {1'b1,1'b0,f3}: MUL..REMU = 1_0000..1_0111.
//    - f3[2]=0 uses MUL_LAT; f3[2]=1 uses DIV_LAT. out_multi=1.
//  - Not defined: f7=0000001 -> illegal; WAIT state and counter are not built; busy tied 0; out_multi tied 0.
// STRUCTURE
//  - alu_ctrl_pkg: op_e enum (OP_W-sized codes incl. OP_ILLEGAL), aluop_e enum, f7 constants,
//    state_e {IDLE,WAIT,VALID}.
//  - Sub-module alu_ctrl_decode: purely combinational decode -> {op, illegal, multi, lat}.
//  - Top module: FSM, latency counter ($clog2(max(MUL_LAT,DIV_LAT)+1) bits), output registers.
// TESTING
//  1. Reset mid-WAIT (DIV accepted, reset at +5) -> all outputs at reset values the same cycle;
//     in_ready=1 after release.
//  2. aluop=10, rtype=1, f3=000, f7=0100000 accepted at N -> out_valid at N+1, out_op=01010.
//     Same with rtype=0 -> 01011.
//  3. out_ready=0 for 4 cycles holding XOR -> out_op=00011 stable, in_ready=0. Release at T ->
//     next op accepted at T, output at T+1 with no bubble.
//  4. (MEXT_EN) MUL f3=000 accepted at N -> busy N+1..N+2, out_valid at N+3, out_op=10000, out_multi=1.
//     DIVU at N -> out_valid at N+33.
//  5. Flush during WAIT at cycle N+10 of a DIV -> busy=0, out_valid=0 at N+11; never asserted for that op.
//  6. aluop=01, f3=010 -> out_illegal=1, out_op=11111 at N+1.
//     Without MEXT_EN, f7=0000001 -> illegal, busy never high.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - Shared types and constants for the ALU control issue stage
package alu_ctrl_pkg;

    typedef enum logic [4:0] {
        OP_AND     = 5'b00000,
        OP_OR      = 5'b00001,
        OP_LUI     = 5'b00010,
        OP_XOR     = 5'b00011,
        OP_SLL     = 5'b00100,
        OP_SRL     = 5'b00101,
        OP_BLT     = 5'b00110,
        OP_BGE     = 5'b00111,
        OP_BEQ     = 5'b01000,
        OP_BNE     = 5'b01001,
        OP_SUB     = 5'b01010,
        OP_ADD     = 5'b01011,
        OP_SLT     = 5'b01100,
        OP_SRA     = 5'b01101,
        OP_SLTU    = 5'b01110,
        OP_MUL     = 5'b10000,
        OP_MULH    = 5'b10001,
        OP_MULHSU  = 5'b10010,
        OP_MULHU   = 5'b10011,
        OP_DIV     = 5'b10100,
        OP_DIVU    = 5'b10101,
        OP_REM     = 5'b10110,
        OP_REMU    = 5'b10111,
        OP_ILLEGAL = 5'b11111
    } op_e;

    typedef enum logic [1:0] {
        ALUOP_MEM = 2'b00,
        ALUOP_BR  = 2'b01,
        ALUOP_RI  = 2'b10,
        ALUOP_JL  = 2'b11
    } aluop_e;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        VALID = 2'b10
    } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - Combinational ALUOp/Funct3/Funct7 decode to op, illegal, multi and latency
// M-extension group decoded only when ALU_CTRL_MEXT_EN is defined.
import alu_ctrl_pkg::*;

module alu_ctrl_decode #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic [1:0]       aluop,
    input  logic             rtype,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    output op_e              op,
    output logic             illegal,
    output logic             multi,
    output logic [CNT_W-1:0] lat
);

    // Latency only matters when multi is set; funct3[2] splits MUL from DIV/REM.
    assign lat = funct3[2] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

    always_comb begin
        op      = OP_ADD;
        illegal = 1'b0;
        multi   = 1'b0;
        case (aluop_e'(aluop))
            ALUOP_MEM: op = OP_ADD;
            ALUOP_JL:  op = OP_LUI;
            ALUOP_BR: begin
                case (funct3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    default: illegal = 1'b1;
                endcase
            end
            ALUOP_RI: begin
                if (rtype && funct7 == F7_MEXT) begin
`ifdef ALU_CTRL_MEXT_EN
                    op    = op_e'({2'b10, funct3});
                    multi = 1'b1;
`else
                    illegal = 1'b1;
`endif
                end else if (rtype && funct7 != F7_BASE && funct7 != F7_ALT) begin
                    illegal = 1'b1;
                end else begin
                    case (funct3)
                        3'b000:  op = (rtype && funct7 == F7_ALT) ? OP_SUB : OP_ADD;
                        3'b001:  op = OP_SLL;
                        3'b010:  op = OP_SLT;
                        3'b011:  op = OP_SLTU;
                        3'b100:  op = OP_XOR;
                        3'b101:  op = funct7[5] ? OP_SRA : OP_SRL;
                        3'b110:  op = OP_OR;
                        default: op = OP_AND;
                    endcase
                end
            end
            default: op = OP_ADD;
        endcase
        if (illegal) begin
            op = OP_ILLEGAL;
        end
    end

endmodule

// File: rtl/alu_ctrl_issue.sv
// rtl/alu_ctrl_issue.sv - Registered, handshaked ALU control issue stage between ID and EX
// Multi-cycle MUL/DIV wait path is built only when ALU_CTRL_MEXT_EN is defined.
import alu_ctrl_pkg::*;

module alu_ctrl_issue #(
    parameter int OP_W    = 5,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 33
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_aluop,
    input  logic            in_rtype,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic            in_flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] out_op,
    output logic            out_illegal,
    output logic            out_multi,
    output logic            busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    op_e              dec_op;
    logic             dec_illegal;
    logic             dec_multi;
    logic [CNT_W-1:0] dec_lat;
    logic [OP_W-1:0]  op_d;

    state_e           state_q;
    logic             valid_q;
    logic             illegal_q;
    logic [OP_W-1:0]  op_q;

    logic             busy_w;
    logic             wait_done;
    logic             go_wait;
    logic             accept;

    alu_ctrl_decode #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_decode (
        .aluop   (in_aluop),
        .rtype   (in_rtype),
        .funct3  (in_funct3),
        .funct7  (in_funct7),
        .op      (dec_op),
        .illegal (dec_illegal),
        .multi   (dec_multi),
        .lat     (dec_lat)
    );

    assign op_d     = dec_illegal ? {OP_W{1'b1}} : OP_W'(dec_op);
    assign in_ready = ~busy_w & (~valid_q | out_ready);
    assign accept   = in_valid & in_ready & ~in_flush;

`ifdef ALU_CTRL_MEXT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             multi_q;

    // Countdown loaded with LAT-1 so the op becomes valid exactly LAT cycles after accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            multi_q <= 1'b0;
        end else if (in_flush) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (accept) begin
            multi_q <= dec_multi;
            if (dec_multi) begin
                cnt_q  <= dec_lat - CNT_W'(1);
                busy_q <= 1'b1;
            end
        end else if (busy_q) begin
            if (cnt_q == CNT_W'(1)) begin
                cnt_q  <= '0;
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign busy_w    = busy_q;
    assign wait_done = busy_q & (cnt_q == CNT_W'(1));
    assign go_wait   = dec_multi;
    assign out_multi = multi_q;
`else
    logic unused_dec;

    assign unused_dec = dec_multi ^ (^dec_lat);
    assign busy_w     = 1'b0;
    assign wait_done  = 1'b0;
    assign go_wait    = 1'b0;
    assign out_multi  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            op_q      <= OP_W'(OP_ADD);
        end else if (in_flush) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else if (accept) begin
            op_q      <= op_d;
            illegal_q <= dec_illegal;
            if (go_wait) begin
                state_q <= WAIT;
                valid_q <= 1'b0;
            end else begin
                state_q <= VALID;
                valid_q <= 1'b1;
            end
        end else begin
            case (state_q)
                VALID: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (wait_done) begin
                        state_q <= VALID;
                        valid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_w;
    assign out_valid   = valid_q;
    assign out_op      = op_q;
    assign out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// tb/tb_alu_ctrl_issue.sv - Directed and randomized checks of alu_ctrl_issue against a transaction model
module tb_alu_ctrl_issue;

    localparam int OP_W    = 5;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 33;
`ifdef ALU_CTRL_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      in_aluop = 2'b00;
    logic            in_rtype = 1'b0;
    logic [2:0]      in_funct3 = 3'b000;
    logic [6:0]      in_funct7 = 7'b0;
    logic            in_flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [OP_W-1:0] out_op;
    logic            out_illegal;
    logic            out_multi;
    logic            busy;

    always #5 clk = ~clk;

    alu_ctrl_issue #(.OP_W(OP_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_aluop    (in_aluop),
        .in_rtype    (in_rtype),
        .in_funct3   (in_funct3),
        .in_funct7   (in_funct7),
        .in_flush    (in_flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_illegal (out_illegal),
        .out_multi   (out_multi),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    // Model: an op is pending until its due cycle, then held as valid until consumed.
    bit         m_valid = 1'b0;
    bit         m_pend  = 1'b0;
    int         m_due   = 0;
    logic [4:0] m_op    = 5'b01011;
    bit         m_ill   = 1'b0;
    bit         m_multi = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_decode(input logic [1:0] a, input bit rt, input logic [2:0] f3,
                                       input logic [6:0] f7, output logic [4:0] op,
                                       output bit ill, output bit mul, output int lat);
        op = 5'd11; ill = 1'b0; mul = 1'b0; lat = 1;
        if (a == 2'b11) op = 5'd2;
        else if (a == 2'b01) begin
            if (f3 == 3'd0) op = 5'd8;
            else if (f3 == 3'd1) op = 5'd9;
            else if (f3 == 3'd4) op = 5'd6;
            else if (f3 == 3'd5) op = 5'd7;
            else ill = 1'b1;
        end else if (a == 2'b10) begin
            if (rt && f7 == 7'd1) begin
                if (MEXT) begin
                    op = 5'd16 + 5'(f3); mul = 1'b1; lat = f3[2] ? DIV_LAT : MUL_LAT;
                end else ill = 1'b1;
            end else if (rt && f7 != 7'd0 && f7 != 7'd32) ill = 1'b1;
            else begin
                case (f3)
                    3'd0: op = (rt && f7 == 7'd32) ? 5'd10 : 5'd11;
                    3'd1: op = 5'd4;
                    3'd2: op = 5'd12;
                    3'd3: op = 5'd14;
                    3'd4: op = 5'd3;
                    3'd5: op = f7[5] ? 5'd13 : 5'd5;
                    3'd6: op = 5'd1;
                    default: op = 5'd0;
                endcase
            end
        end
        if (ill) op = 5'd31;
    endfunction

    task automatic cyc(input bit v, input logic [1:0] a, input bit rt, input logic [2:0] f3,
                       input logic [6:0] f7, input bit fl, input bit ordy);
        logic [4:0] r_op;
        bit r_ill, r_mul, exp_rdy;
        int r_lat;
        in_valid = v; in_aluop = a; in_rtype = rt; in_funct3 = f3; in_funct7 = f7;
        in_flush = fl; out_ready = ordy;
        @(negedge clk);
        if (m_pend && cyc_n >= m_due) begin
            m_pend = 1'b0; m_valid = 1'b1;
        end
        exp_rdy = !m_pend && (!m_valid || ordy);
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, m_valid);
        check("busy", busy, m_pend);
        if (m_valid) begin
            check("out_op", out_op, m_op);
            check("out_illegal", out_illegal, m_ill);
            check("out_multi", out_multi, m_multi);
        end
        if (fl) begin
            m_valid = 1'b0; m_pend = 1'b0;
        end else if (v && exp_rdy) begin
            ref_decode(a, rt, f3, f7, r_op, r_ill, r_mul, r_lat);
            m_op = r_op; m_ill = r_ill; m_multi = r_mul;
            m_valid = 1'b0; m_pend = 1'b1; m_due = cyc_n + r_lat;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 3'b000, 7'd0, 1'b0, ordy);
    endtask

    task automatic async_reset();
        in_valid = 1'b0; in_flush = 1'b0; out_ready = 1'b0;
        #3 reset = 1'b1;
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_op", out_op, 5'b01011);
        check("rst_illegal", out_illegal, 1'b0);
        check("rst_multi", out_multi, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        cyc_n++;
        m_valid = 1'b0; m_pend = 1'b0; m_op = 5'b01011; m_ill = 1'b0; m_multi = 1'b0;
    endtask

    initial begin
        logic [6:0] f7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("init_valid", out_valid, 1'b0);
        check("init_op", out_op, 5'b01011);
        check("init_busy", busy, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("init_ready", in_ready, 1'b1);

        cyc(1'b1, 2'b10, 1'b1, 3'b000, 7'b0100000, 1'b0, 1'b1);
        check("sub_valid", out_valid, 1'b1);
        check("sub_op", out_op, 5'b01010);
        cyc(1'b1, 2'b10, 1'b0, 3'b000, 7'b0100000, 1'b0, 1'b1);
        check("addi_op", out_op, 5'b01011);

        cyc(1'b1, 2'b10, 1'b0, 3'b100, 7'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 2'b10, 1'b1, 3'b111, 7'd0, 1'b0, 1'b0);
            check("hold_op", out_op, 5'b00011);
            check("hold_ready", in_ready, 1'b0);
        end
        cyc(1'b1, 2'b10, 1'b1, 3'b111, 7'd0, 1'b0, 1'b1);
        check("b2b_valid", out_valid, 1'b1);
        check("b2b_op", out_op, 5'b00000);

        cyc(1'b1, 2'b01, 1'b0, 3'b010, 7'd0, 1'b0, 1'b1);
        check("br_ill", out_illegal, 1'b1);
        check("br_ill_op", out_op, 5'b11111);
        idle(1, 1'b1);

`ifdef ALU_CTRL_MEXT_EN
        cyc(1'b1, 2'b10, 1'b1, 3'b000, 7'd1, 1'b0, 1'b1);
        check("mul_busy1", busy, 1'b1);
        idle(1, 1'b1);
        check("mul_busy2", busy, 1'b1);
        idle(1, 1'b1);
        check("mul_valid", out_valid, 1'b1);
        check("mul_op", out_op, 5'b10000);
        check("mul_multi", out_multi, 1'b1);
        cyc(1'b1, 2'b10, 1'b1, 3'b101, 7'd1, 1'b0, 1'b1);
        idle(31, 1'b1);
        check("divu_early", out_valid, 1'b0);
        idle(1, 1'b1);
        check("divu_valid", out_valid, 1'b1);
        check("divu_op", out_op, 5'b10101);
        cyc(1'b1, 2'b10, 1'b1, 3'b100, 7'd1, 1'b0, 1'b1);
        idle(9, 1'b1);
        cyc(1'b0, 2'b00, 1'b0, 3'b000, 7'd0, 1'b1, 1'b1);
        check("flush_busy", busy, 1'b0);
        check("flush_valid", out_valid, 1'b0);
        idle(30, 1'b1);
        cyc(1'b1, 2'b10, 1'b1, 3'b110, 7'd1, 1'b0, 1'b1);
        idle(4, 1'b1);
        async_reset();
`else
        cyc(1'b1, 2'b10, 1'b1, 3'b000, 7'd1, 1'b0, 1'b1);
        check("noext_ill", out_illegal, 1'b1);
        check("noext_op", out_op, 5'b11111);
        check("noext_busy", busy, 1'b0);
        check("noext_multi", out_multi, 1'b0);
        cyc(1'b1, 2'b10, 1'b0, 3'b110, 7'd0, 1'b0, 1'b1);
        idle(1, 1'b0);
        async_reset();
`endif

        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 3))
                0: f7 = 7'd0;
                1: f7 = 7'd32;
                2: f7 = 7'd1;
                default: f7 = 7'($urandom);
            endcase
            cyc(($urandom_range(0, 9) < 7), 2'($urandom), 1'($urandom), 3'($urandom), f7,
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
